// File: rtl/obi_pkg.sv
// Minimal OBI request/response bundles shared by the masters_req/masters_resp arrays.
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/strela_pkg.sv
// Shared types for the input/output memory node engines.
package strela_pkg;

  typedef enum logic [1:0] {
    S_IMN_IDLE,
    S_IMN_ISSUE,
    S_IMN_DRAIN,
    S_IMN_DONE
  } imn_fsm_t;

  localparam logic [3:0] IMN_WORD_BE = 4'hF;

endpackage

// File: rtl/imn_rd_fifo.sv
// Synchronous response buffer for the IMN read engine; exposes occupancy for credit flow control.
module imn_rd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the empty flag masks stale entries, so plain RAM can be used.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o))
    else $error("imn_rd_fifo: push into full FIFO");

endmodule

// File: rtl/imn_stream_reader.sv
// IMN read engine: strided OBI reads, in-order response buffering, valid/ready stream out.
module imn_stream_reader
  import obi_pkg::*, strela_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] addr_i,
  input  logic [15:0] size_i,
  input  logic [15:0] stride_i,
  output obi_req_t    obi_req_o,
  input  obi_resp_t   obi_resp_i,
  output logic [31:0] data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  imn_fsm_t    state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [15:0] size_q, size_d;
  logic [15:0] stride_q, stride_d;
  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] pop_cnt_q, pop_cnt_d;
  logic [CW-1:0] outst_q, outst_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic [31:0]   fifo_data;
  logic [CW:0]   credit_sum;
  logic          req, grant, rsp_push, pop, last_grant, last_pop;

  imn_rd_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rsp_push),
    .data_i  (obi_resp_i.rdata),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Every granted read owns a FIFO slot until it is popped, so the buffer cannot overflow.
  always_comb begin
    credit_sum = {1'b0, outst_q} + {1'b0, fifo_count};
    req        = (state_q == S_IMN_ISSUE) && (credit_sum < DEPTH_C);
    grant      = req && obi_resp_i.gnt;
    rsp_push   = obi_resp_i.rvalid && (outst_q != '0);
    pop        = !fifo_empty && ready_i;
    last_grant = grant && (issue_cnt_q == size_q - 16'd1);
    last_pop   = pop && (pop_cnt_q == size_q - 16'd1);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    stride_d    = stride_q;
    issue_cnt_d = issue_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    outst_d     = outst_q;

    if (grant) begin
      addr_d      = addr_q + {16'h0000, stride_q};
      issue_cnt_d = issue_cnt_q + 16'd1;
    end
    if (pop) pop_cnt_d = pop_cnt_q + 16'd1;

    case ({grant, rsp_push})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    case (state_q)
      S_IMN_IDLE: begin
        if (start_i) begin
          addr_d      = addr_i;
          size_d      = size_i;
          stride_d    = stride_i;
          issue_cnt_d = '0;
          pop_cnt_d   = '0;
          state_d     = (size_i == 16'd0) ? S_IMN_DONE : S_IMN_ISSUE;
        end
      end
      S_IMN_ISSUE: if (last_grant) state_d = S_IMN_DRAIN;
      S_IMN_DRAIN: if (last_pop)   state_d = S_IMN_DONE;
      S_IMN_DONE:  state_d = S_IMN_IDLE;
      default:     state_d = S_IMN_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IMN_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      stride_q    <= '0;
      issue_cnt_q <= '0;
      pop_cnt_q   <= '0;
      outst_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      stride_q    <= stride_d;
      issue_cnt_q <= issue_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      outst_q     <= outst_d;
    end
  end

  always_comb begin
    obi_req_o = '0;
    if (req) begin
      obi_req_o.req  = 1'b1;
      obi_req_o.addr = addr_q;
      obi_req_o.be   = IMN_WORD_BE;
    end
  end

  assign valid_o = !fifo_empty;
  assign data_o  = fifo_data;
  assign busy_o  = (state_q != S_IMN_IDLE);
  assign done_o  = (state_q == S_IMN_DONE);

  a_req_held: assert property (@(posedge clk_i) disable iff (rst_i)
      obi_req_o.req && !obi_resp_i.gnt |=> obi_req_o.req && $stable(obi_req_o.addr))
    else $error("imn_stream_reader: request withdrawn or changed before grant");

  a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
      obi_resp_i.rvalid |-> (outst_q != '0))
    else $error("imn_stream_reader: rvalid with no read outstanding");

  a_credit: assert property (@(posedge clk_i) disable iff (rst_i)
      rsp_push |-> !fifo_full)
    else $error("imn_stream_reader: response arrived with FIFO full");

endmodule
